// File: rtl/sao_lcu_ctrl.sv
// rtl/sao_lcu_ctrl.sv - SAO LCU load/process sequencer with frame SRAM addressing.
// Optional SAO_FAST_PASS_EN: OFF/BO LCUs use 2 cycles per pixel (phases 1 and 3).
module sao_lcu_ctrl #(
  parameter int FRAME_LOG2   = 7,
  parameter int MAX_LCU_LOG2 = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_en,
  input  logic [1:0]                sao_type,
  input  logic                      sao_eo_class,
  input  logic [2:0]                lcu_x,
  input  logic [2:0]                lcu_y,
  input  logic [1:0]                lcu_size,
  output logic                      busy,
  output logic                      finish,
  output logic                      buf_we,
  output logic [2*MAX_LCU_LOG2-1:0] buf_wa,
  output logic [2*MAX_LCU_LOG2-1:0] buf_ra,
  output logic [1:0]                phase,
  output logic                      nb_use,
  output logic                      sram_we,
  output logic [2*FRAME_LOG2-1:0]   sram_a
);
  localparam int AW = 2 * MAX_LCU_LOG2;
  localparam int FW = 2 * FRAME_LOG2;

  typedef enum logic [1:0] {LOAD, PROC, DONE} state_t;
  state_t state, state_n;

  logic [AW-1:0] cnt, pix;
  logic [1:0]    ph, type_q;
  logic          busy_q, cls_q;
  logic [2:0]    lx_q, ly_q, k_q, k_in, lmax;
  logic          accept, lcu_end, frame_last, fast, start_fast;
  logic [AW-1:0] last_in, last_q, nmask, px, py, step, ra_a, ra_b;
  logic          edge_lo, edge_hi, nb;
  logic [FW-1:0] row, col, sa;

  function automatic logic [2:0] size_log2(input logic [1:0] s);
    return (s == 2'd0) ? 3'd4 : (s == 2'd1) ? 3'd5 : 3'd6;
  endfunction

`ifdef SAO_FAST_PASS_EN
  assign fast       = (type_q != 2'd2);
  assign start_fast = (sao_type != 2'd2);
`else
  assign fast       = 1'b0;
  assign start_fast = 1'b0;
`endif

  assign k_in    = size_log2(lcu_size);
  assign last_in = ~({AW{1'b1}} << {k_in, 1'b0});
  assign last_q  = ~({AW{1'b1}} << {k_q, 1'b0});
  assign nmask   = ~({AW{1'b1}} << k_q);
  assign px      = pix & nmask;
  assign py      = pix >> k_q;
  assign step    = sao_eo_class_q_step();
  assign lmax    = 3'((8'd1 << (3'(FRAME_LOG2) - k_q)) - 8'd1);
  assign frame_last = (lx_q == lmax) && (ly_q == lmax);

  function automatic logic [AW-1:0] sao_eo_class_q_step();
    return cls_q ? (nmask + AW'(1)) : AW'(1);
  endfunction

  // Neighbours that fall outside the LCU collapse onto the centre sample.
  assign edge_lo = cls_q ? (py == '0)    : (px == '0);
  assign edge_hi = cls_q ? (py == nmask) : (px == nmask);
  assign ra_a    = edge_lo ? pix : pix - step;
  assign ra_b    = edge_hi ? pix : pix + step;
  assign nb      = (type_q == 2'd2) && !edge_lo && !edge_hi;

  assign row = (FW'(ly_q) << k_q) + FW'(py);
  assign col = (FW'(lx_q) << k_q) + FW'(px);
  assign sa  = (row << FRAME_LOG2) + col;

  assign buf_wa = cnt;
  assign busy   = busy_q;
  assign finish = (state == DONE);
  assign phase  = ph;

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    lcu_end = 1'b0;
    buf_we  = 1'b0;
    buf_ra  = '0;
    sram_we = 1'b0;
    sram_a  = '0;
    nb_use  = 1'b0;
    case (state)
      LOAD: begin
        accept = in_en && !busy_q;
        buf_we = accept;
        if (accept && cnt == last_in) state_n = PROC;
      end
      PROC: begin
        nb_use = nb;
        case (ph)
          2'd0:    buf_ra = ra_a;
          2'd1:    buf_ra = pix;
          2'd2:    buf_ra = ra_b;
          default: begin
            buf_ra  = pix;
            sram_we = 1'b1;
            sram_a  = sa;
          end
        endcase
        if (ph == 2'd3 && pix == last_q) begin
          lcu_end = 1'b1;
          state_n = frame_last ? DONE : LOAD;
        end
      end
      DONE:    state_n = DONE;
      default: state_n = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= LOAD;
      cnt    <= '0;
      pix    <= '0;
      ph     <= 2'd0;
      busy_q <= 1'b0;
      type_q <= 2'd0;
      cls_q  <= 1'b0;
      lx_q   <= 3'd0;
      ly_q   <= 3'd0;
      k_q    <= 3'd4;
    end else begin
      state <= state_n;
      if (accept) begin
        if (cnt == last_in) begin
          cnt    <= '0;
          busy_q <= 1'b1;
          type_q <= sao_type;
          cls_q  <= sao_eo_class;
          lx_q   <= lcu_x;
          ly_q   <= lcu_y;
          k_q    <= k_in;
          pix    <= '0;
          ph     <= start_fast ? 2'd1 : 2'd0;
        end else begin
          cnt <= cnt + AW'(1);
        end
      end
      if (state == PROC) begin
        if (lcu_end) begin
          pix    <= '0;
          ph     <= 2'd0;
          busy_q <= frame_last;
        end else if (ph == 2'd3) begin
          pix <= pix + AW'(1);
          ph  <= fast ? 2'd1 : 2'd0;
        end else if (fast && ph == 2'd1) begin
          ph <= 2'd3;
        end else begin
          ph <= ph + 2'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sao_lcu_ctrl.sv
// tb/tb_sao_lcu_ctrl.sv - scoreboard bench for sao_lcu_ctrl.
module tb_sao_lcu_ctrl;
  logic        clk = 1'b0;
  logic        reset, in_en, sao_eo_class;
  logic [1:0]  sao_type, lcu_size;
  logic [2:0]  lcu_x, lcu_y;
  logic        busy, finish, buf_we, nb_use, sram_we;
  logic [11:0] buf_wa, buf_ra;
  logic [1:0]  phase;
  logic [13:0] sram_a;

  sao_lcu_ctrl dut (
    .clk(clk), .reset(reset), .in_en(in_en), .sao_type(sao_type),
    .sao_eo_class(sao_eo_class), .lcu_x(lcu_x), .lcu_y(lcu_y), .lcu_size(lcu_size),
    .busy(busy), .finish(finish), .buf_we(buf_we), .buf_wa(buf_wa), .buf_ra(buf_ra),
    .phase(phase), .nb_use(nb_use), .sram_we(sram_we), .sram_a(sram_a)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [30:0] val;
    logic [30:0] mask;
  } rec_t;

  rec_t        exp_q[$];
  rec_t        r;
  int          total = 0;
  int          bad = 0;
  int          proc_idx = 0;
  int          we_pulses = 0;
  int          finish_rises = 0;
  logic        finish_d = 1'b0;
  logic [13:0] last_sa = '0;
  logic [11:0] ra_log[0:16383];
  logic [13:0] sa_log[0:16383];
  logic        nb_log[0:16383];
  logic [1:0]  ph_log[0:16383];
  int          cyc, odd_ph;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  always @(negedge clk) begin
    if (buf_we) we_pulses++;
    if (finish === 1'b1 && finish_d !== 1'b1) finish_rises++;
    finish_d = finish;
    if (sram_we === 1'b1) last_sa = sram_a;
    if (reset === 1'b0 && busy === 1'b1 && finish === 1'b0) begin
      if (proc_idx < 16384) begin
        ra_log[proc_idx] = buf_ra;
        sa_log[proc_idx] = sram_a;
        nb_log[proc_idx] = nb_use;
        ph_log[proc_idx] = phase;
      end
      proc_idx++;
      if (exp_q.size() == 0) chk("extra_proc_cycle", 32'd1, 32'd0);
      else begin
        r = exp_q.pop_front();
        chk("proc", 32'({buf_we, phase, nb_use, sram_we, buf_ra, sram_a} & r.mask), 32'(r.val));
      end
    end
  end

  task automatic push_proc(input logic [1:0] ty, input logic cls, input int lx, input int ly, input int k);
    int n, px, py, a, b, sa, ra;
    bit fast, lo, hi, nb;
    rec_t e;
    n = 1 << k;
`ifdef SAO_FAST_PASS_EN
    fast = (ty != 2'd2);
`else
    fast = 1'b0;
`endif
    for (int p = 0; p < n * n; p++) begin
      px = p % n;
      py = p / n;
      lo = cls ? (py == 0) : (px == 0);
      hi = cls ? (py == n - 1) : (px == n - 1);
      nb = (ty == 2'd2) && !lo && !hi;
      a  = lo ? p : (cls ? p - n : p - 1);
      b  = hi ? p : (cls ? p + n : p + 1);
      sa = (ly * n + py) * 128 + lx * n + px;
      for (int j = 0; j < 4; j++) begin
        if (fast && (j == 0 || j == 2)) continue;
        ra = (j == 0) ? a : (j == 1) ? p : (j == 2) ? b : 0;
        e.val  = {1'b0, 2'(j), nb, (j == 3), 12'(ra), (j == 3) ? 14'(sa) : 14'd0};
        e.mask = {5'b11111, (j == 3) ? 12'h000 : 12'hFFF, (j == 3) ? 14'h3FFF : 14'h0000};
        exp_q.push_back(e);
      end
    end
  endtask

  // Entry and exit aligned to posedge+1; non-final pixels carry junk parameters.
  task automatic load_lcu(input logic [1:0] ty, input logic cls, input logic [2:0] lx,
                          input logic [2:0] ly, input logic [1:0] sz, input bit gaps);
    int k, nn, i;
    bit last;
    k  = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 5 : 6;
    nn = 1 << (2 * k);
    i  = 0;
    lcu_size = sz;
    while (i < nn) begin
      if (gaps && $urandom_range(0, 7) == 0) begin
        in_en = 1'b0;
        @(negedge clk);
        chk("gap_no_we", 32'(buf_we), 32'd0);
      end else begin
        in_en = 1'b1;
        last  = (i == nn - 1);
        sao_type     = last ? ty  : 2'($urandom_range(0, 3));
        sao_eo_class = last ? cls : 1'($urandom_range(0, 1));
        lcu_x        = last ? lx  : 3'($urandom_range(0, 7));
        lcu_y        = last ? ly  : 3'($urandom_range(0, 7));
        if (last) begin
          push_proc(ty, cls, int'(lx), int'(ly), k);
          proc_idx = 0;
        end
        @(negedge clk);
        chk("load_we_wa", 32'({busy, buf_we, buf_wa}), 32'({1'b0, 1'b1, 12'(i)}));
        i++;
      end
      @(posedge clk); #1;
    end
    chk("busy_after_last", 32'(busy), 32'd1);
  endtask

  task automatic wait_proc(output int cycles);
    cycles = 0;
    while (busy && !finish && cycles < 20000) begin
      @(posedge clk); #1;
      cycles++;
    end
    in_en = 1'b0;
    if (cycles >= 20000) chk("proc_timeout", 32'd1, 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  localparam int BO_CYC = `ifdef SAO_FAST_PASS_EN 512 `else 1024 `endif;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_en = 1'b0; sao_type = '0; sao_eo_class = 1'b0;
    lcu_x = '0; lcu_y = '0; lcu_size = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl", 32'({busy, finish, buf_we, sram_we, phase, nb_use}), 32'd0);
    chk("reset_addr", 32'({buf_wa, buf_ra}), 32'd0);
    chk("reset_sram_a", 32'(sram_a), 32'd0);
    reset = 1'b0;

    // N=32, OFF, in_en held high through PROC
    we_pulses = 0;
    load_lcu(2'd0, 1'b0, 3'd0, 3'd0, 2'd1, 1'b0);
    wait_proc(cyc);
    chk("t1_proc_cycles", 32'(cyc), 32'd4096);
    chk("t1_we_pulses", 32'(we_pulses), 32'd1024);
    chk("t1_busy_fell", 32'(busy), 32'd0);

    // EO class 0, N=32, lcu (1,2)
    load_lcu(2'd2, 1'b0, 3'd1, 3'd2, 2'd1, 1'b1);
    wait_proc(cyc);
    chk("t2_proc_cycles", 32'(cyc), 32'd4096);
    chk("t2_ra_a", 32'(ra_log[132]), 32'd32);
    chk("t2_ra_c", 32'(ra_log[133]), 32'd33);
    chk("t2_ra_b", 32'(ra_log[134]), 32'd34);
    chk("t2_sram_a", 32'(sa_log[135]), 32'd8353);
    chk("t2_nb_in", 32'(nb_log[133]), 32'd1);
    chk("t2_nb_edge", 32'(nb_log[128]), 32'd0);
    chk("t2_ra_clamp", 32'(ra_log[128]), 32'd32);

    // EO class 1, N=16
    load_lcu(2'd2, 1'b1, 3'd3, 3'd4, 2'd0, 1'b1);
    wait_proc(cyc);
    chk("t3_proc_cycles", 32'(cyc), 32'd1024);
    chk("t3_nb_top", 32'(nb_log[20]), 32'd0);
    chk("t3_ra_a", 32'(ra_log[68]), 32'd1);
    chk("t3_ra_c", 32'(ra_log[69]), 32'd17);
    chk("t3_ra_b", 32'(ra_log[70]), 32'd33);
    chk("t3_nb_in", 32'(nb_log[68]), 32'd1);

    // BO then EO at N=16: pass length depends on the fast-pass build
    load_lcu(2'd1, 1'b0, 3'd2, 3'd2, 2'd0, 1'b0);
    wait_proc(cyc);
    chk("bo_proc_cycles", 32'(cyc), 32'(BO_CYC));
    odd_ph = 0;
    for (int i = 0; i < cyc && i < 16384; i++)
      if (ph_log[i] == 2'd0 || ph_log[i] == 2'd2) odd_ph++;
    chk("bo_phase02_seen", 32'(odd_ph), (BO_CYC == 512) ? 32'd0 : 32'd512);
    load_lcu(2'd2, 1'b0, 3'd5, 3'd1, 2'd0, 1'b0);
    wait_proc(cyc);
    chk("eo_proc_cycles", 32'(cyc), 32'd1024);

    // Reset in the middle of the third LCU's PROC
    load_lcu(2'd0, 1'b0, 3'd0, 3'd1, 2'd0, 1'b0);
    wait_proc(cyc);
    load_lcu(2'd3, 1'b1, 3'd1, 3'd1, 2'd0, 1'b0);
    wait_proc(cyc);
    load_lcu(2'd2, 1'b0, 3'd7, 3'd7, 2'd0, 1'b0);
    repeat (300) begin @(posedge clk); #1; end
    reset = 1'b1;
    in_en = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    chk("mid_reset", 32'({busy, finish, sram_we, phase}), 32'd0);
    reset = 1'b0;
    load_lcu(2'd1, 1'b0, 3'd4, 3'd4, 2'd0, 1'b1);
    wait_proc(cyc);
    chk("post_reset_cycles", 32'(cyc), 32'(BO_CYC));

    // Frame completion at N=16: only lcu (7,7) ends the frame
    chk("no_finish_yet", 32'(finish_rises), 32'd0);
    load_lcu(2'd2, 1'b0, 3'd3, 3'd5, 2'd0, 1'b1);
    wait_proc(cyc);
    load_lcu(2'd1, 1'b1, 3'd7, 3'd6, 2'd0, 1'b1);
    wait_proc(cyc);
    chk("finish_low_76", 32'(finish), 32'd0);
    load_lcu(2'd2, 1'b1, 3'd7, 3'd7, 2'd0, 1'b1);
    wait_proc(cyc);
    chk("final_cycles", 32'(cyc), 32'd1024);
    chk("final_busy_finish", 32'({busy, finish}), 32'd3);
    chk("final_sram_a", 32'(last_sa), 32'd16383);
    in_en = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("done_no_we", 32'({buf_we, busy, finish}), 32'd3);
    end
    in_en = 1'b0;
    chk("finish_rises", 32'(finish_rises), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sao_lcu_ctrl.md
Name: sao_lcu_ctrl

Overview:
- Control and scheduling unit for the SAO (Sample Adaptive Offset) filter engine.
- Accepts one LCU of raster pixels into a local LCU buffer, then sequences per-pixel neighbour/centre reads and result writes into the 128x128 frame SRAM.
- Drives the busy/finish handshake seen by the pixel source.
- Owns all addressing, phase sequencing and LCU-boundary detection; the offset arithmetic sits in a separate datapath.

Parameters:
- FRAME_LOG2, 7, log2 of frame width/height in pixels (128).
- MAX_LCU_LOG2, 6, log2 of the largest LCU edge (64); sets buf address width 2*MAX_LCU_LOG2.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- in_en  in  1  pixel valid from source
- sao_type  in  2  0=OFF, 1=BO, 2=EO, 3=treated as OFF
- sao_eo_class  in  1  0=horizontal (x-1,x+1), 1=vertical (y-1,y+1)
- lcu_x  in  3  LCU column of incoming LCU
- lcu_y  in  3  LCU row of incoming LCU
- lcu_size  in  2  0=16, 1=32, 2=64, 3=treated as 64
- busy  out  1  source must not present pixels while high
- finish  out  1  whole frame written; sticky until reset
- buf_we  out  1  write incoming pixel into LCU buffer
- buf_wa  out  12  LCU buffer write address (raster inside LCU)
- buf_ra  out  12  LCU buffer read address
- phase  out  2  current per-pixel phase in PROC
- nb_use  out  1  high: EO with both neighbours inside LCU
- sram_we  out  1  frame SRAM write strobe
- sram_a  out  14  frame SRAM address

Behaviour:
- Reset (sync, checked every edge, overrides everything, including mid-LOAD/PROC): state=LOAD, all counters=0, busy=0, finish=0, buf_we=0, sram_we=0, buf_wa=buf_ra=sram_a=0, phase=0, nb_use=0.
- N = 16<<min(lcu_size,2); LCUs per side L = 128/N.
- States: LOAD, PROC, DONE.
- LOAD:
  - Pixel accepted on any edge with in_en=1 and busy=0.
  - Same cycle: buf_we=1 (combinational), buf_wa = pixel count.
  - On the N*N-th accepted pixel, latch sao_type, sao_eo_class, lcu_x, lcu_y, N, then enter PROC.
  - busy is registered: high from the edge that accepts the last pixel.
- PROC:
  - Pixel index p = 0..N*N-1, raster order; px = p mod N, py = p / N.
  - Four cycles per pixel, phase 0..3:
    - phase0: buf_ra = A neighbour (x-1 or y-1).
    - phase1: buf_ra = centre.
    - phase2: buf_ra = B neighbour (x+1 or y+1).
    - phase3: sram_we=1, sram_a = ((lcu_y*N+py)<<7) + lcu_x*N + px.
  - Buffer read latency is 1 cycle; the datapath latches data on phases 1, 2 and 3.
  - Out-of-LCU neighbour addresses are clamped to the centre address.
  - nb_use = (type==EO) and neighbours inside LCU. For class 0 this means px!=0 and px!=N-1; for class 1, py!=0 and py!=N-1.
  - When nb_use=0 the datapath passes the centre through (OFF/boundary) or applies BO.
- End of LCU (phase3 of p=N*N-1):
  - If lcu_x==L-1 and lcu_y==L-1: go to DONE.
  - Otherwise go to LOAD; busy=0 from the next edge.
- DONE: busy=1, finish=1; stays in DONE until reset.
- Pixels offered with in_en while busy=1 are ignored; the buffer is not written.
- lcu_x, lcu_y and the SAO parameters are sampled only with the last pixel of an LCU.
- Address arithmetic is unsigned 14-bit; it cannot overflow for legal lcu_x/lcu_y < L.

Optional Feature:
- Macro SAO_FAST_PASS_EN.
- Defined: when nb_use would be 0 for every pixel of the LCU (latched type OFF or BO), each pixel takes 2 cycles: phase1 (centre read), then phase3 (write). Phases 0 and 2 are skipped. EO LCUs still use 4 cycles per pixel, including boundary pixels.
- Undefined: every pixel takes 4 cycles regardless of type.

Test Plan:
- Reset and lcu_size=1: stream 1024 pixels with in_en held high. Check:
  - buf_we pulses 1024 times.
  - busy rises after the 1024th accept.
  - PROC lasts 4096 cycles.
  - busy falls afterwards.
- EO class 0, lcu_x=1, lcu_y=2, N=32, pixel p=33 (px=1, py=1): buf_ra sequence 32, 33, 34; sram_a = 65*128+33 = 8353; nb_use=1. At p=32 (px=0): nb_use=0 and buf_ra A = 32.
- EO class 1, N=16: pixel py=0 gives nb_use=0. Pixel p=17 gives buf_ra sequence 1, 17, 33.
- Full frame at lcu_size=0 (64 LCUs): finish rises exactly once, after the final write to sram_a=16383. It stays high; busy stays high.
- Assert reset mid-PROC of the third LCU. Next edge: busy=0, finish=0, sram_we=0. A fresh LCU loads from buf_wa=0.
- With SAO_FAST_PASS_EN and a BO LCU at N=16: PROC lasts 512 cycles; phase shows only 1 and 3. An EO LCU still takes 1024 cycles.
